// File: rtl/clk_bringup_pkg.sv
// Shared types and constants for the oscillator -> rPLL -> CLKDIV bring-up sequencer.
package clk_bringup_pkg;

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    localparam int LOSS_CNT_W = 8;
    localparam int TMO_CNT_W  = 4;

    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;
    localparam logic [TMO_CNT_W-1:0]  TMO_CNT_MAX  = 4'd15;

endpackage

// File: rtl/clk_bringup_seq_sync2.sv
// Two-flop synchronizer for a level crossing into clk; both flops clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_bringup_seq.sv
// Clock-tree bring-up sequencer: PLL reset pulse, lock qualification, staged CLKDIV release.
// Optional WAIT_LOCK timeout is built when CLKSEQ_LOCK_TIMEOUT_EN is defined.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RESET_PLL | pll_reset high for exactly PLL_RST_CYCLES, all stages held
// ST_WAIT_LOCK | PLL running, counting consecutive synchronized-lock cycles
// ST_RELEASE   | releasing CLKDIV stages one per RELEASE_GAP, bit 0 first
// ST_READY     | whole tree running on a valid lock
module clk_bringup_seq
    import clk_bringup_pkg::*;
#(
    parameter int N_DIV          = 6,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 64,
    parameter int RELEASE_GAP    = 8,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_lock,
    input  logic                  rearm,
    output logic                  pll_reset,
    output logic [N_DIV-1:0]      div_resetn,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [TMO_CNT_W-1:0]  timeout_cnt
);

    localparam int RST_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam int STB_W = $clog2(LOCK_STABLE) + 1;
    localparam int GAP_W = $clog2(RELEASE_GAP) + 1;
    localparam int IDX_W = $clog2(N_DIV) + 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIV);

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic [STB_W-1:0] stable_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] stage_idx;

    logic lock_s;
    logic sync_clear;
    logic lock_lost;
    logic stable_done;
    logic tmo_hit;

    // Lock seen while the PLL is held in reset is stale, so the synchronizer is
    // flushed for the whole pulse and only post-release lock is qualified.
    assign sync_clear = reset | pll_reset;

    sync2 u_lock_sync (
        .clk   (clk),
        .reset (sync_clear),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign lock_lost   = ((state == ST_RELEASE) || (state == ST_READY)) && !lock_s;
    assign stable_done = (state == ST_WAIT_LOCK) && lock_s && (stable_cnt == STB_LAST);

`ifdef CLKSEQ_LOCK_TIMEOUT_EN
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || (state != ST_WAIT_LOCK)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A stable lock on the last budget cycle still counts as success.
    assign tmo_hit = (state == ST_WAIT_LOCK) && (tmo_cnt == TMO_LAST) && !stable_done;
`else
    logic unused_lock_timeout;
    assign unused_lock_timeout = (LOCK_TIMEOUT != 0);
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RESET_PLL;
            pll_reset     <= 1'b1;
            div_resetn    <= '0;
            ready         <= 1'b0;
            rst_cnt       <= '0;
            stable_cnt    <= '0;
            gap_cnt       <= '0;
            stage_idx     <= '0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else if (rearm || lock_lost || tmo_hit) begin
            state      <= ST_RESET_PLL;
            pll_reset  <= 1'b1;
            div_resetn <= '0;
            ready      <= 1'b0;
            rst_cnt    <= '0;
            stable_cnt <= '0;
            gap_cnt    <= '0;
            stage_idx  <= '0;
            // A rearm restart is deliberate, so it never counts as a fault.
            if (!rearm && lock_lost && (lock_loss_cnt != LOSS_CNT_MAX)) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
            if (!rearm && tmo_hit && (timeout_cnt != TMO_CNT_MAX)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt   <= '0;
                        pll_reset <= 1'b0;
                        state     <= ST_WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (stable_done) begin
                        stable_cnt <= '0;
                        gap_cnt    <= '0;
                        stage_idx  <= '0;
                        state      <= ST_RELEASE;
                    end else if (lock_s) begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end else begin
                        stable_cnt <= '0;
                    end
                end

                ST_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (stage_idx == IDX_LAST) begin
                            stage_idx <= '0;
                            ready     <= 1'b1;
                            state     <= ST_READY;
                        end else begin
                            for (int k = 0; k < N_DIV; k++) begin
                                if (stage_idx == IDX_W'(k)) begin
                                    div_resetn[k] <= 1'b1;
                                end
                            end
                            stage_idx <= stage_idx + 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                ST_READY: begin
                    ready <= 1'b1;
                end

                default: begin
                    state      <= ST_RESET_PLL;
                    pll_reset  <= 1'b1;
                    div_resetn <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_bringup_seq.sv
// Directed bench for clk_bringup_seq with N_DIV=3, PLL_RST_CYCLES=4, LOCK_STABLE=8, RELEASE_GAP=2, LOCK_TIMEOUT=32.
module tb_clk_bringup_seq;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       pll_lock = 1'b0;
    logic       rearm    = 1'b0;
    logic       pll_reset;
    logic [2:0] div_resetn;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [3:0] timeout_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    clk_bringup_seq #(
        .N_DIV          (3),
        .PLL_RST_CYCLES (4),
        .LOCK_STABLE    (8),
        .RELEASE_GAP    (2),
        .LOCK_TIMEOUT   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .rearm         (rearm),
        .pll_reset     (pll_reset),
        .div_resetn    (div_resetn),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    // cyc holds the index of the edge just taken; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic restart(input logic lock);
        reset    = 1'b1;
        rearm    = 1'b0;
        pll_lock = lock;
        step();
        step();
        reset = 1'b0;
        cyc   = -1;
    endtask

    // Expected {pll_reset, div_resetn, ready} after edge e for a RESET_PLL entry at
    // edge b with lock present: pll_reset low from b+4, lock_s qualifies from b+6,
    // RELEASE entered at b+14, stages at b+16/18/20, ready at b+22; d = extra delay.
    function automatic logic [4:0] exp_seq(input int e, input int b, input int d);
        logic       pr;
        logic [2:0] dv;
        logic       rd;
        pr    = (e >= b) && (e < b + 4);
        dv[0] = (e >= b + 16 + d);
        dv[1] = (e >= b + 18 + d);
        dv[2] = (e >= b + 20 + d);
        rd    = (e >= b + 22 + d);
        return {pr, dv, rd};
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        pll_lock = 1'b1;
        rearm    = 1'b1;
        repeat (3) step();
        checks++;
        if ({pll_reset, div_resetn, ready} !== 5'b1_000_0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", {pll_reset, div_resetn, ready}, 5'b1_000_0);
        end
        checks++;
        if (lock_loss_cnt !== 8'd0 || timeout_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_counters got loss=%0d tmo=%0d want 0/0", lock_loss_cnt, timeout_cnt);
        end
        rearm = 1'b0;
    endtask

    task automatic test_nominal();
        logic [4:0] exp;
        restart(1'b1);
        while (cyc < 30) begin
            step();
            exp = exp_seq(cyc, -1, 0);
            checks++;
            if ({pll_reset, div_resetn, ready} !== exp) begin
                failures++;
                $display("FAIL nominal cyc=%0d got=%b want=%b", cyc, {pll_reset, div_resetn, ready}, exp);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'd0 || timeout_cnt !== 4'd0) begin
            failures++;
            $display("FAIL nominal_counters got loss=%0d tmo=%0d want 0/0", lock_loss_cnt, timeout_cnt);
        end
    endtask

    // One-cycle pll_lock dip seen by the FSM after 5 qualified cycles delays release by 6.
    task automatic test_glitch();
        logic [4:0] exp;
        restart(1'b1);
        while (cyc < 30) begin
            if (cyc + 1 == 9)  pll_lock = 1'b0;
            if (cyc + 1 == 10) pll_lock = 1'b1;
            step();
            exp = exp_seq(cyc, -1, 6);
            checks++;
            if ({pll_reset, div_resetn, ready} !== exp || lock_loss_cnt !== 8'd0) begin
                failures++;
                $display("FAIL glitch cyc=%0d got=%b loss=%0d want=%b loss=0",
                         cyc, {pll_reset, div_resetn, ready}, lock_loss_cnt, exp);
            end
        end
    endtask

    // Continues from test_glitch: ready since edge 27, lock dropped into edge 31.
    task automatic test_loss_ready();
        logic [4:0] exp;
        logic [7:0] exp_loss;
        while (cyc < 70) begin
            if (cyc + 1 == 31) pll_lock = 1'b0;
            if (cyc + 1 == 34) pll_lock = 1'b1;
            step();
            exp      = (cyc < 33) ? exp_seq(cyc, -1, 6) : exp_seq(cyc, 33, 0);
            exp_loss = (cyc < 33) ? 8'd0 : 8'd1;
            checks++;
            if ({pll_reset, div_resetn, ready} !== exp || lock_loss_cnt !== exp_loss) begin
                failures++;
                $display("FAIL loss_ready cyc=%0d got=%b loss=%0d want=%b loss=%0d",
                         cyc, {pll_reset, div_resetn, ready}, lock_loss_cnt, exp, exp_loss);
            end
        end
    endtask

    task automatic test_loss_release();
        logic [4:0] exp;
        restart(1'b1);
        while (cyc < 18) begin
            if (cyc + 1 == 16) pll_lock = 1'b0;
            step();
            exp = (cyc < 18) ? exp_seq(cyc, -1, 0) : 5'b1_000_0;
            checks++;
            if ({pll_reset, div_resetn, ready} !== exp) begin
                failures++;
                $display("FAIL loss_release cyc=%0d got=%b want=%b", cyc, {pll_reset, div_resetn, ready}, exp);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            failures++;
            $display("FAIL loss_release_count got=%0d want=1", lock_loss_cnt);
        end
        pll_lock = 1'b1;
    endtask

    // Continues from test_loss_release with one loss already counted.
    task automatic test_loss_saturation();
        logic seen;
        logic abort;
        logic [7:0] exp_loss;
        abort = 1'b0;
        for (int i = 2; i <= 257 && !abort; i++) begin
            seen = 1'b0;
            for (int t = 0; t < 64 && !seen; t++) begin
                step();
                if (div_resetn[0] === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                failures++;
                abort = 1'b1;
                $display("FAIL sat_wait_release loss_index=%0d div_resetn=%b want bit0=1 within 64 cycles", i, div_resetn);
            end else begin
                pll_lock = 1'b0;
                seen = 1'b0;
                for (int t = 0; t < 64 && !seen; t++) begin
                    step();
                    if (pll_reset === 1'b1) seen = 1'b1;
                end
                pll_lock = 1'b1;
                if (!seen) begin
                    checks++;
                    failures++;
                    abort = 1'b1;
                    $display("FAIL sat_wait_reset loss_index=%0d pll_reset=%b want 1 within 64 cycles", i, pll_reset);
                end else if (i >= 254) begin
                    exp_loss = (i > 255) ? 8'd255 : 8'(i);
                    checks++;
                    if (lock_loss_cnt !== exp_loss) begin
                        failures++;
                        $display("FAIL sat_count loss_index=%0d got=%0d want=%0d", i, lock_loss_cnt, exp_loss);
                    end
                end
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (lock_loss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL sat_reset_clear got=%0d want=0", lock_loss_cnt);
        end
    endtask

    // rearm lands on edge 27, the same edge the FSM first sees lock_s low in READY.
    task automatic test_rearm_collision();
        logic [4:0] exp;
        restart(1'b1);
        while (cyc < 60) begin
            if (cyc + 1 == 25) pll_lock = 1'b0;
            if (cyc + 1 == 27) rearm = 1'b1;
            if (cyc + 1 == 28) begin
                rearm    = 1'b0;
                pll_lock = 1'b1;
            end
            step();
            exp = (cyc < 27) ? exp_seq(cyc, -1, 0) : exp_seq(cyc, 27, 0);
            checks++;
            if ({pll_reset, div_resetn, ready} !== exp || lock_loss_cnt !== 8'd0) begin
                failures++;
                $display("FAIL rearm_collision cyc=%0d got=%b loss=%0d want=%b loss=0",
                         cyc, {pll_reset, div_resetn, ready}, lock_loss_cnt, exp);
            end
        end
    endtask

`ifdef CLKSEQ_LOCK_TIMEOUT_EN
    // Lock never arrives: RESET_PLL entries at edges -1 + 36k, timeout_cnt = k capped at 15.
    task automatic test_timeout();
        logic       exp_pr;
        logic [3:0] exp_tmo;
        int         k;
        restart(1'b0);
        while (cyc < 36 * 17 + 5) begin
            step();
            exp_pr  = (((cyc + 1) % 36) < 4);
            k       = (cyc + 1) / 36;
            exp_tmo = (k > 15) ? 4'd15 : 4'(k);
            checks++;
            if (pll_reset !== exp_pr || timeout_cnt !== exp_tmo || div_resetn !== 3'b000 || ready !== 1'b0) begin
                failures++;
                $display("FAIL timeout cyc=%0d got pll_reset=%b tmo=%0d div=%b ready=%b want pll_reset=%b tmo=%0d div=000 ready=0",
                         cyc, pll_reset, timeout_cnt, div_resetn, ready, exp_pr, exp_tmo);
            end
        end
    endtask
`else
    task automatic test_timeout();
        logic exp_pr;
        restart(1'b0);
        while (cyc < 100) begin
            step();
            exp_pr = (cyc < 3);
            checks++;
            if (pll_reset !== exp_pr || timeout_cnt !== 4'd0 || div_resetn !== 3'b000) begin
                failures++;
                $display("FAIL no_timeout cyc=%0d got pll_reset=%b tmo=%0d div=%b want pll_reset=%b tmo=0 div=000",
                         cyc, pll_reset, timeout_cnt, div_resetn, exp_pr);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_loss_ready();
        test_loss_release();
        test_loss_saturation();
        test_rearm_collision();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_bringup_seq.md
# clk_bringup_seq

Sequences clock bring-up for the oscillator → rPLL → CLKDIV-chain LED clock tree. It holds the PLL in reset for a fixed interval and waits for a stable, synchronized lock. It then releases the CLKDIV stages one at a time, first stage first, and tears the tree back down when lock is lost. It runs on the free-running on-chip oscillator clock, which is the PLL input clock, so it never depends on the clocks it controls.

## Interface
Parameters:
- N_DIV, 6: number of CLKDIV stages controlled.
- PLL_RST_CYCLES, 16: cycles pll_reset is held high per attempt.
- LOCK_STABLE, 64: consecutive synchronized-lock cycles required before release.
- RELEASE_GAP, 8: cycles between successive stage releases.
- LOCK_TIMEOUT, 4096: WAIT_LOCK cycle budget (only with CLKSEQ_LOCK_TIMEOUT_EN).

Ports:
- clk  in  1  oscillator clock.
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- rearm  in  1  single-cycle request to restart the full sequence.
- pll_reset  out  1  PLL reset, active-high.
- div_resetn  out  N_DIV  per-stage CLKDIV resetn; bit 0 is the first stage.
- ready  out  1  high while all stages run with a valid lock.
- lock_loss_cnt  out  8  count of lock losses in RELEASE/READY; saturates at 255.
- timeout_cnt  out  4  count of WAIT_LOCK timeouts; saturates at 15.

## Operation
- pll_lock passes through a 2-flop synchronizer to give lock_s. All decisions use lock_s.
- States: RESET_PLL, WAIT_LOCK, RELEASE, READY.
- RESET_PLL: pll_reset=1, div_resetn=0, ready=0. After PLL_RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK: pll_reset=0. The stable counter increments while lock_s=1 and clears when lock_s=0. When it reaches LOCK_STABLE → RELEASE. A lock drop here is not counted as a loss.
- RELEASE: a gap counter runs from entry. div_resetn[k] rises RELEASE_GAP·(k+1) cycles after entry. Bits only rise, in ascending order. RELEASE_GAP cycles after div_resetn[N_DIV-1] rises → READY.
- READY: ready=1, all div_resetn=1, pll_reset=0.
- Lock loss (lock_s=0 in RELEASE or READY): next cycle → RESET_PLL with all div_resetn=0, ready=0, and lock_loss_cnt+1 (saturating).
- rearm=1 in any state: next cycle → RESET_PLL. No counter changes.
- rearm and lock loss in the same cycle: rearm wins; lock_loss_cnt is unchanged.
- reset has priority over everything.

## Timing
- Reset values: state RESET_PLL, pll_reset=1, div_resetn=0, ready=0, lock_loss_cnt=0, timeout_cnt=0, all internal counters 0.
- All outputs are registered.
- Latency:
  - pll_lock edge to lock_s: 2 cycles.
  - lock_s to state/output change: 1 cycle.
- Minimum time from reset deassert to ready: PLL_RST_CYCLES + 2 + LOCK_STABLE + RELEASE_GAP·(N_DIV+1) cycles, assuming lock held from time 0.
- The time in RESET_PLL is exact: pll_reset is high for PLL_RST_CYCLES cycles on every entry, including re-entries.
- Counter widths: each is $clog2 of its parameter + 1. None wrap.

## Configuration
- CLKSEQ_LOCK_TIMEOUT_EN defined: a timeout counter runs in WAIT_LOCK and clears on entry. If it reaches LOCK_TIMEOUT before the stable condition is met → RESET_PLL, timeout_cnt+1 (saturating).
- If the stable condition and the timeout occur in the same cycle, stable wins.
- Not defined: WAIT_LOCK waits indefinitely, and timeout_cnt is constant 0.

## Structure
- Package clk_bringup_pkg holds:
  - the state enum (2-bit);
  - the lock_loss_cnt and timeout_cnt width constants;
  - the saturation limits.
- One sub-module: sync2, a 2-flop synchronizer with a reset value of 0, used for pll_lock.

## Test plan
All scenarios use N_DIV=3, PLL_RST_CYCLES=4, LOCK_STABLE=8, RELEASE_GAP=2, LOCK_TIMEOUT=32.
- Nominal bring-up:
  - Stimulus: reset deasserted at cycle 0, pll_lock=1 from cycle 0.
  - Response: pll_reset falls at cycle 4; div_resetn goes 001/011/111 at 2-cycle spacing; ready=1; all outputs stable thereafter.
- Glitchy lock in WAIT_LOCK:
  - Stimulus: a 1-cycle pll_lock low after 5 stable cycles.
  - Response: stable count restarts; release is delayed accordingly; lock_loss_cnt=0.
- Lock loss in READY:
  - Stimulus: pll_lock dropped while ready=1.
  - Response: 3 cycles later div_resetn=000, ready=0, pll_reset=1, lock_loss_cnt=1; re-sequences when lock returns.
- Lock loss mid-RELEASE:
  - Stimulus: pll_lock dropped after div_resetn=011.
  - Response: div_resetn=000 and lock_loss_cnt increments.
  - Stimulus: 256 losses.
  - Response: lock_loss_cnt saturates at 255.
- rearm collides with lock loss:
  - Stimulus: rearm asserted in READY in the same cycle lock_s falls.
  - Response: → RESET_PLL; lock_loss_cnt unchanged; pll_reset held exactly 4 cycles.
- Timeout (macro defined):
  - Stimulus: pll_lock held 0.
  - Response: pll_reset re-pulses every 4+32 cycles; timeout_cnt counts to 15 and holds.
  - Without the macro: pll_reset stays 0 and timeout_cnt stays 0.
